// File: rtl/core_dec_pkg.sv
// ============================================================================
// core_dec_pkg : decode-bundle field layout, hazard encodings, entry type
// Revision     : 1.0
// ============================================================================
`default_nettype none

package core_dec_pkg;

  localparam int CTRL_W = 20;

  // Control bundle layout, LSB first
  localparam int CTRL_WB_SX_OP_LSB = 0;   // 3 bits
  localparam int CTRL_MUX_BUS_LSB  = 3;   // 3 bits
  localparam int CTRL_ALU_OP_LSB   = 6;   // 4 bits
  localparam int CTRL_ALU_CND_LSB  = 10;  // 3 bits
  localparam int CTRL_WE_BIT       = 13;
  localparam int CTRL_L1D_VAL_BIT  = 14;
  localparam int CTRL_L1D_COP_BIT  = 15;
  localparam int CTRL_L1D_SIZE_LSB = 16;  // 2 bits
  localparam int CTRL_HAZ_CMD_LSB  = 18;  // 2 bits

  localparam int X0_IDX = 0;

  typedef enum logic [1:0] {
    HAZ_NONE = 2'd0,
    HAZ_RS1  = 2'd1,
    HAZ_RS2  = 2'd2,
    HAZ_BOTH = 2'd3
  } haz_cmd_e;

  typedef struct packed {
    logic [31:0]       pc;
    logic [CTRL_W-1:0] ctrl;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic [4:0]        rd;
    logic [31:0]       src1;
    logic [31:0]       src2;
  } dec_entry_t;

endpackage

`default_nettype wire

// File: rtl/core_dec_snoop.sv
// ============================================================================
// core_dec_snoop : replaces an operand with the writeback value on a match
// Revision       : 1.0
// ============================================================================
`default_nettype none

module core_dec_snoop #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] rs_i,
  input  logic [DATA_W-1:0] src_i,
  input  logic              wb_we_i,
  input  logic [REG_AW-1:0] wb_rd_i,
  input  logic [DATA_W-1:0] wb_data_i,
  output logic [DATA_W-1:0] src_o
);
  import core_dec_pkg::*;

  logic hit;

  // x0 is hard-wired zero, so a write to it must never leak into an operand
  assign hit   = wb_we_i && (wb_rd_i != REG_AW'(X0_IDX)) && (wb_rd_i == rs_i);
  assign src_o = hit ? wb_data_i : src_i;

endmodule

`default_nettype wire

// File: rtl/core_dec_buf.sv
// ============================================================================
// core_dec_buf : DEPTH-entry decode-output FIFO with writeback operand snoop
// Revision     : 1.0  (optional same-cycle bypass: CORE_DEC_BUF_BYPASS_EN)
// ============================================================================
`default_nettype none

module core_dec_buf #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int CTRL_W = core_dec_pkg::CTRL_W,
  parameter int DEPTH  = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       kill,
  input  logic                       in_val,
  output logic                       in_rdy,
  input  logic [DATA_W-1:0]          in_pc,
  input  logic [CTRL_W-1:0]          in_ctrl,
  input  logic [REG_AW-1:0]          in_rs1,
  input  logic [REG_AW-1:0]          in_rs2,
  input  logic [REG_AW-1:0]          in_rd,
  input  logic [DATA_W-1:0]          in_src1,
  input  logic [DATA_W-1:0]          in_src2,
  input  logic                       wb_we,
  input  logic [REG_AW-1:0]          wb_rd,
  input  logic [DATA_W-1:0]          wb_data,
  output logic                       out_val,
  input  logic                       out_rdy,
  output logic [DATA_W-1:0]          out_pc,
  output logic [CTRL_W-1:0]          out_ctrl,
  output logic [REG_AW-1:0]          out_rs1,
  output logic [REG_AW-1:0]          out_rs2,
  output logic [REG_AW-1:0]          out_rd,
  output logic [DATA_W-1:0]          out_src1,
  output logic [DATA_W-1:0]          out_src2,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  import core_dec_pkg::*;

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [DATA_W-1:0] pc_q   [DEPTH];
  logic [CTRL_W-1:0] ctrl_q [DEPTH];
  logic [REG_AW-1:0] rs1_q  [DEPTH];
  logic [REG_AW-1:0] rs2_q  [DEPTH];
  logic [REG_AW-1:0] rd_q   [DEPTH];
  logic [DATA_W-1:0] src1_q [DEPTH];
  logic [DATA_W-1:0] src2_q [DEPTH];
  logic [DATA_W-1:0] src1_snp [DEPTH];
  logic [DATA_W-1:0] src2_snp [DEPTH];
  logic [DATA_W-1:0] in_src1_snp;
  logic [DATA_W-1:0] in_src2_snp;

  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             empty, push, pop, bypass;

  assign empty  = (count_q == '0);
  assign in_rdy = (count_q != FULL_CNT);
`ifdef CORE_DEC_BUF_BYPASS_EN
  assign bypass = empty & in_val & out_rdy & ~kill;
`else
  assign bypass = 1'b0;
`endif
  assign push  = in_val & in_rdy & ~bypass;
  assign pop   = ~empty & out_rdy;
  assign count = count_q;

  generate
    for (genvar i = 0; i < DEPTH; i++) begin : g_entry
      core_dec_snoop #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_snp1 (
        .rs_i(rs1_q[i]), .src_i(src1_q[i]), .wb_we_i(wb_we),
        .wb_rd_i(wb_rd), .wb_data_i(wb_data), .src_o(src1_snp[i])
      );
      core_dec_snoop #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_snp2 (
        .rs_i(rs2_q[i]), .src_i(src2_q[i]), .wb_we_i(wb_we),
        .wb_rd_i(wb_rd), .wb_data_i(wb_data), .src_o(src2_snp[i])
      );
    end
  endgenerate

  // Shared by the push path and the bypass path
  core_dec_snoop #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_in_snp1 (
    .rs_i(in_rs1), .src_i(in_src1), .wb_we_i(wb_we),
    .wb_rd_i(wb_rd), .wb_data_i(wb_data), .src_o(in_src1_snp)
  );
  core_dec_snoop #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_in_snp2 (
    .rs_i(in_rs2), .src_i(in_src2), .wb_we_i(wb_we),
    .wb_rd_i(wb_rd), .wb_data_i(wb_data), .src_o(in_src2_snp)
  );

  // Storage needs no reset: nothing is ever shown from an unoccupied slot
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      src1_q[i] <= src1_snp[i];
      src2_q[i] <= src2_snp[i];
    end
    if (push) begin
      pc_q[wr_ptr_q]   <= in_pc;
      ctrl_q[wr_ptr_q] <= in_ctrl;
      rs1_q[wr_ptr_q]  <= in_rs1;
      rs2_q[wr_ptr_q]  <= in_rs2;
      rd_q[wr_ptr_q]   <= in_rd;
      src1_q[wr_ptr_q] <= in_src1_snp;
      src2_q[wr_ptr_q] <= in_src2_snp;
    end
  end

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (kill) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_comb begin
    out_val  = 1'b0;
    out_pc   = '0;
    out_ctrl = '0;
    out_rs1  = '0;
    out_rs2  = '0;
    out_rd   = '0;
    out_src1 = '0;
    out_src2 = '0;
    if (!empty) begin
      out_val  = 1'b1;
      out_pc   = pc_q[rd_ptr_q];
      out_ctrl = ctrl_q[rd_ptr_q];
      out_rs1  = rs1_q[rd_ptr_q];
      out_rs2  = rs2_q[rd_ptr_q];
      out_rd   = rd_q[rd_ptr_q];
      out_src1 = src1_q[rd_ptr_q];
      out_src2 = src2_q[rd_ptr_q];
    end else if (bypass) begin
      out_val  = 1'b1;
      out_pc   = in_pc;
      out_ctrl = in_ctrl;
      out_rs1  = in_rs1;
      out_rs2  = in_rs2;
      out_rd   = in_rd;
      out_src1 = in_src1_snp;
      out_src2 = in_src2_snp;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_core_dec_buf.sv
// ============================================================================
// tb_core_dec_buf : directed + random checks of core_dec_buf against a queue model
// Revision        : 1.0
// ============================================================================
`default_nettype none

module tb_core_dec_buf;

  localparam int DATA_W = 32;
  localparam int REG_AW = 5;
  localparam int CTRL_W = 20;
  localparam int DEPTH  = 2;
  localparam int CNT_W  = $clog2(DEPTH+1);
`ifdef CORE_DEC_BUF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct {
    logic [DATA_W-1:0] pc;
    logic [CTRL_W-1:0] ctrl;
    logic [REG_AW-1:0] rs1, rs2, rd;
    logic [DATA_W-1:0] src1, src2;
  } ent_t;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              kill = 1'b0, in_val = 1'b0, out_rdy = 1'b0, wb_we = 1'b0;
  logic              in_rdy, out_val;
  logic [DATA_W-1:0] in_pc = '0, in_src1 = '0, in_src2 = '0, wb_data = '0;
  logic [CTRL_W-1:0] in_ctrl = '0;
  logic [REG_AW-1:0] in_rs1 = '0, in_rs2 = '0, in_rd = '0, wb_rd = '0;
  logic [DATA_W-1:0] out_pc, out_src1, out_src2;
  logic [CTRL_W-1:0] out_ctrl;
  logic [REG_AW-1:0] out_rs1, out_rs2, out_rd;
  logic [CNT_W-1:0]  count;

  core_dec_buf #(.DATA_W(DATA_W), .REG_AW(REG_AW), .CTRL_W(CTRL_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .kill(kill), .in_val(in_val), .in_rdy(in_rdy),
    .in_pc(in_pc), .in_ctrl(in_ctrl), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
    .in_src1(in_src1), .in_src2(in_src2), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .out_val(out_val), .out_rdy(out_rdy), .out_pc(out_pc), .out_ctrl(out_ctrl),
    .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
    .out_src1(out_src1), .out_src2(out_src2), .count(count)
  );

  always #5 clk = ~clk;

  ent_t q[$];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] snp(input logic [REG_AW-1:0] rs, input logic [DATA_W-1:0] v);
    if (wb_we && wb_rd != 0 && wb_rd == rs) return wb_data;
    return v;
  endfunction

  task automatic drive(input logic [DATA_W-1:0] pc, input logic [REG_AW-1:0] r1,
                       input logic [REG_AW-1:0] r2, input logic [DATA_W-1:0] s1,
                       input logic [DATA_W-1:0] s2);
    in_val  = 1'b1;
    in_pc   = pc;
    in_ctrl = pc[CTRL_W-1:0] ^ 20'h5A5A5;
    in_rs1  = r1;
    in_rs2  = r2;
    in_rd   = r1 ^ r2;
    in_src1 = s1;
    in_src2 = s2;
  endtask

  // Checks all outputs against the model, then advances model and DUT one clock.
  task automatic cycle();
    ent_t h, n;
    bit   byp, v;
    int   sz;
    #1;
    sz  = q.size();
    byp = BYP && sz == 0 && in_val && out_rdy && !kill;
    n = '{pc: in_pc, ctrl: in_ctrl, rs1: in_rs1, rs2: in_rs2, rd: in_rd,
          src1: snp(in_rs1, in_src1), src2: snp(in_rs2, in_src2)};
    if (sz != 0)  h = q[0];
    else if (byp) h = n;
    else          h = '{pc: '0, ctrl: '0, rs1: '0, rs2: '0, rd: '0, src1: '0, src2: '0};
    v = (sz != 0) || byp;
    chk("count",    count,    sz);
    chk("in_rdy",   in_rdy,   sz != DEPTH);
    chk("out_val",  out_val,  v);
    chk("out_pc",   out_pc,   h.pc);
    chk("out_ctrl", out_ctrl, h.ctrl);
    chk("out_rs1",  out_rs1,  h.rs1);
    chk("out_rs2",  out_rs2,  h.rs2);
    chk("out_rd",   out_rd,   h.rd);
    chk("out_src1", out_src1, h.src1);
    chk("out_src2", out_src2, h.src2);
    if (kill) begin
      q.delete();
    end else begin
      if (sz != 0 && out_rdy) void'(q.pop_front());
      foreach (q[i]) begin
        q[i].src1 = snp(q[i].rs1, q[i].src1);
        q[i].src2 = snp(q[i].rs2, q[i].src2);
      end
      if (in_val && sz < DEPTH && !byp) q.push_back(n);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #1 rst = 1'b1;
    @(negedge clk);
    #1;
    chk("rst_count",   count,   0);
    chk("rst_in_rdy",  in_rdy,  1);
    chk("rst_out_val", out_val, 0);
    chk("rst_out_pc",  out_pc,  0);
    rst = 1'b0;

    // Single push then drain
    out_rdy = 1'b1;
    drive(32'h100, 5'd1, 5'd2, 32'h11, 32'h22);
`ifdef CORE_DEC_BUF_BYPASS_EN
    #1;
    chk("byp_val", out_val, 1);
    chk("byp_pc",  out_pc,  32'h100);
    cycle();
    in_val = 1'b0;
    #1 chk("byp_cnt", count, 0);
`else
    cycle();
    in_val = 1'b0;
    #1;
    chk("lat1_val", out_val, 1);
    chk("lat1_pc",  out_pc,  32'h100);
`endif
    cycle();
    cycle();

    // Fill while blocked; third push held off
    out_rdy = 1'b0;
    drive(32'h100, 5'd3, 5'd4, 32'h33, 32'h44); cycle();
    drive(32'h104, 5'd5, 5'd6, 32'h55, 32'h66); cycle();
    drive(32'h108, 5'd7, 5'd8, 32'h77, 32'h88); cycle();
    cycle();
    #1;
    chk("full_rdy", in_rdy, 0);
    chk("full_cnt", count,  2);
    in_val  = 1'b0;
    out_rdy = 1'b1;
    #1 chk("pop0_pc", out_pc, 32'h100);
    cycle();
    #1 chk("pop1_pc", out_pc, 32'h104);
    cycle();
    cycle();

    // Writeback snoop, including a write to x0
    out_rdy = 1'b0;
    drive(32'h180, 5'd5, 5'd0, 32'h1111, 32'h2222); cycle();
    in_val = 1'b0;
    wb_we = 1'b1; wb_rd = 5'd5; wb_data = 32'hDEAD; cycle();
    wb_we = 1'b0;
    #1 chk("snp_src1", out_src1, 32'hDEAD);
    cycle();
    wb_we = 1'b1; wb_rd = 5'd0; wb_data = 32'hBEEF; cycle();
    wb_we = 1'b0;
    #1;
    chk("x0_src1", out_src1, 32'hDEAD);
    chk("x0_src2", out_src2, 32'h2222);
    out_rdy = 1'b1; cycle();
    cycle();

    // Kill on a full buffer with a simultaneous push
    out_rdy = 1'b0;
    drive(32'h200, 5'd1, 5'd1, 32'h1, 32'h2); cycle();
    drive(32'h204, 5'd2, 5'd2, 32'h3, 32'h4); cycle();
    kill = 1'b1; out_rdy = 1'b1;
    drive(32'h300, 5'd3, 5'd3, 32'h5, 32'h6); cycle();
    kill = 1'b0; in_val = 1'b0;
    #1;
    chk("kill_cnt", count,   0);
    chk("kill_val", out_val, 0);
    cycle();
    cycle();

    // Streaming push+pop across pointer wrap
    out_rdy = 1'b1;
    for (int k = 0; k < 10; k++) begin
      drive(32'h400 + 32'(4 * k), 5'(k), 5'(k + 1), 32'(k), 32'(k * 3));
      cycle();
    end
    in_val = 1'b0;
    cycle();
    cycle();

    // Random traffic
    for (int k = 0; k < 400; k++) begin
      drive($urandom, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), $urandom, $urandom);
      in_ctrl = 20'($urandom);
      in_rd   = 5'($urandom_range(0, 31));
      in_val  = ($urandom_range(0, 3) != 0);
      out_rdy = ($urandom_range(0, 2) != 0);
      kill    = ($urandom_range(0, 29) == 0);
      wb_we   = $urandom_range(0, 1) != 0;
      wb_rd   = 5'($urandom_range(0, 3));
      wb_data = $urandom;
      cycle();
    end
    kill = 1'b0; wb_we = 1'b0;

    // Asynchronous reset with entries queued
    out_rdy = 1'b0;
    drive(32'h500, 5'd1, 5'd2, 32'h9, 32'hA); cycle();
    drive(32'h504, 5'd1, 5'd2, 32'h9, 32'hA); cycle();
    in_val = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("arst_val", out_val, 0);
    chk("arst_cnt", count,   0);
    chk("arst_pc",  out_pc,  0);
    chk("arst_rdy", in_rdy,  1);
    q.delete();
    @(negedge clk);
    rst = 1'b0;
    cycle();
    cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/core_dec_buf.md
# core_dec_buf

Parametrised decode-output buffer between the decode control and the execute station. It replaces the single decode pipeline register with a DEPTH-entry FIFO of decoded bundles, using a valid/ready handshake on both sides. Operands held in the buffer are refreshed by writeback snooping, so stalled entries never carry stale register values. The block supports full flush on kill, and fetch stalls only when the buffer is full.

## Interface
Parameters:
- DATA_W, 32: operand/PC width
- REG_AW, 5: register address width
- CTRL_W, 20: width of packed decode control bundle (wb_sx_op, mux_bus, alu_op, alu_cnd, we, l1d val/cop/size, haz_cmd)
- DEPTH, 2: entries; power of two, ≥2

Ports (clock and reset first):
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- kill  in  1  flush every entry
- in_val  in  1  decoded instruction valid (fetch ack qualified)
- in_rdy  out  1  buffer can accept; equals not full
- in_pc  in  DATA_W  instruction PC
- in_ctrl  in  CTRL_W  decoded control bundle
- in_rs1, in_rs2, in_rd  in  REG_AW  register indices
- in_src1, in_src2  in  DATA_W  register-file read data
- wb_we  in  1  writeback enable
- wb_rd  in  REG_AW  writeback register
- wb_data  in  DATA_W  writeback value
- out_val  out  1  head entry valid
- out_rdy  in  1  execute accepts head
- out_pc, out_ctrl, out_rs1, out_rs2, out_rd, out_src1, out_src2  out  as inputs  head entry fields
- count  out  $clog2(DEPTH+1)  occupied entries

## Operation
- Push when in_val & in_rdy. Pop when out_val & out_rdy. Circular storage with rd/wr pointers of $clog2(DEPTH) bits that wrap modulo DEPTH. count increments on push only, decrements on pop only, and is unchanged on push+pop.
- in_rdy = (count != DEPTH). It has no combinational dependence on out_rdy, so a full buffer accepts nothing even when it pops in the same cycle.
- out_val = (count != 0). out_* show storage[rd_ptr] and are all zero when empty.
- Writeback snoop: each cycle, for every valid entry, if wb_we && wb_rd != 0 && wb_rd == entry.rs1, then entry.src1 <= wb_data. The same rule applies to rs2/src2. An entry being pushed in a matching cycle stores wb_data instead of in_src*. An entry popped in the same cycle is unaffected; execute forwarding covers that case.
- x0 is never snooped.
- kill: pointers and count go to 0 at the next edge, with priority over a simultaneous push and pop. A push in the kill cycle is dropped. Storage contents are don't-care after kill.
- No output is ever driven from an invalid entry.

## Timing
- Reset (async assert, sync release): count=0, pointers=0, out_val=0, in_rdy=1, all out_* = 0.
- Push-to-out_val latency is 1 cycle (registered). Throughput is 1 per cycle while neither full nor empty.
- Snoop update becomes visible on out_src* the cycle after the wb_we cycle.
- kill asserted in cycle N: out_val=0 and count=0 from cycle N+1.
- Reset asserted mid-operation: outputs clear immediately (asynchronously). Queued entries are lost.

## Configuration
- CORE_DEC_BUF_BYPASS_EN defined: when count==0, in_val=1, out_rdy=1 and kill=0, the input passes combinationally to out_* with out_val=1. Snoop forwarding is applied on that path. No write occurs and count stays 0. Latency is 0 cycles. in_rdy is unchanged.
- Undefined: no combinational in→out path. Latency is always 1 cycle.

## Structure
- core_dec_pkg holds:
  - CTRL_W and the field offsets of the control bundle
  - hazard-cmd encodings
  - a packed entry typedef (pc, ctrl, rs1, rs2, rd, src1, src2)
- Sub-module core_dec_snoop: one instance per operand per entry. It takes rs, src, wb_we, wb_rd and wb_data and returns the refreshed src. It is also reused on the push and bypass paths.
- The top holds the pointers, count, storage array and kill logic.

## Test plan
- Reset, then push pc=0x100 with out_rdy=1 → out_val=1 next cycle with out_pc=0x100; count returns 1→0.
- out_rdy=0, push 3 bundles with DEPTH=2 → in_rdy=0 after the 2nd push, the 3rd is held off, count=2. Release out_rdy → pops in order 0x100, 0x104.
- Entry rs1=5 held, wb_we=1, wb_rd=5, wb_data=0xDEAD → out_src1=0xDEAD next cycle. Repeat with wb_rd=0 → out_src1 unchanged.
- Full buffer plus kill together with in_val=1 → count=0 and out_val=0 next cycle. The pushed bundle never appears.
- Push and pop every cycle for 10 cycles (pointer wrap) → count constant, order preserved.
- With CORE_DEC_BUF_BYPASS_EN, empty buffer, in_val=out_rdy=1, pc=0x200 → out_val=1 and out_pc=0x200 in the same cycle; count stays 0.
